tlb_mgr: RTL and testbench
==========================

Name: tlb_mgr

Overview:
- Initiator side of the TLB maintenance interface: executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB issued by the execute stage.
- Drives the TLB's search port 1, read port, write port and invtlb port, then returns results for CSR update (TLBIDX, TLBEHI, TLBELO0/1, ASID).
- Sits between the EX/MEM pipeline stage and the CSR file. Serialises one TLB op at a time and backpressures the pipeline with valid/ready.

Parameters:
- TLBNUM, 16, number of TLB entries (from shared package).
- TLBIDLEN, 4, index width, equal to log2(TLBNUM).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset (already decided)
- req_valid  in  1  op request
- req_ready  out  1  high only in IDLE
- req_op  in  3  tlb_op_t: SRCH=0, RD=1, WR=2, FILL=3, INV=4
- req_invop  in  5  INVTLB op code
- req_inv_asid  in  10  INVTLB asid operand
- req_inv_va  in  32  INVTLB va operand
- csr_entry  in  tlb_entry_t  entry assembled from TLBEHI/TLBELO0/1/TLBIDX.PS/ASID; e = ~TLBIDX.NE
- csr_index  in  TLBIDLEN  TLBIDX.INDEX
- s_vppn  out  19  search vppn (= csr_entry.vppn)
- s_va_bit12  out  1  tied 0
- s_asid  out  10  search asid
- s_result  in  tlb_result_t  search result
- r_index  out  TLBIDLEN  read index
- r_entry  in  tlb_entry_t  read data
- we  out  1  write strobe
- w_index  out  TLBIDLEN  write index
- w_entry  out  tlb_entry_t  write data
- invtlb_valid  out  1  invalidate strobe
- invtlb_op  out  5  invalidate op code
- invtlb_asid  out  10  invalidate asid
- invtlb_va  out  32  invalidate va
- resp_valid  out  1  result available
- resp_ready  in  1  CSR file accepts result
- resp_op  out  3  op being completed
- resp_found  out  1  SRCH hit, or RD entry valid
- resp_index  out  TLBIDLEN  hit index (SRCH), fill index (FILL)
- resp_entry  out  tlb_entry_t  RD data
- resp_inv_bad  out  1  INVTLB op > 6 (caller raises INE)

Behaviour:
- Reset values: FSM=IDLE, req_ready=1, we=0, invtlb_valid=0, resp_valid=0, all resp_* =0, fill_ptr=0.
- Reset asserted mid-operation aborts the op with no write/invalidate strobe after assertion.
- FSM states: IDLE, EXEC, RESP.
- IDLE: on req_valid & req_ready, latch request fields and go to EXEC.
- EXEC (exactly one cycle), by op:
  - SRCH: s_vppn/s_asid driven from csr_entry; s_result registered at cycle end.
  - RD: r_index = csr_index; r_entry registered.
  - WR: we=1, w_index = csr_index, w_entry = csr_entry.
  - FILL: we=1, w_index = fill_ptr, w_entry = csr_entry; fill_ptr increments and wraps TLBNUM-1 -> 0.
  - INV with op <= 6: invtlb_valid=1 with latched operands.
  - INV with op > 6: no strobe; resp_inv_bad=1.
  - EXEC always goes to RESP.
- RESP: resp_valid=1, resp_* stable until resp_ready. On resp_valid & resp_ready go to IDLE.
- Minimum latency: accept at cycle 0, strobe at cycle 1, resp_valid at cycle 2. Back-to-back throughput is 1 op per 3 cycles.
- Strobe width: we and invtlb_valid are high for exactly one cycle, never simultaneously.
- Read/search data is captured in EXEC only. Later TLB changes do not alter the held resp.
- RD with r_entry.e=0: resp_found=0 and resp_entry is zeroed except ps, so the CSR file clears fields per ISA.
- SRCH miss: resp_found=0; resp_index keeps its previous value.
- csr_entry is sampled in EXEC, not at accept. The pipeline holds CSRs stable, since no CSR write can overtake a blocked TLB op.

Decomposition:
- Shared package: tlb_op_t enum, INVTLB op constants (0..6), TLBNUM/TLBIDLEN, and the existing tlb_entry_t/tlb_result_t.
- One natural sub-module: tlb_fill_ptr (wrapping index counter with increment enable). Its policy can later be swapped for an LFSR without touching the FSM.

Test Plan:
- WR with csr_index=5, vppn=0x1234, ps=12: we pulses once at cycle 1 with w_index=5. A following SRCH on vppn 0x1234 gives resp_found=1, resp_index=5.
- Four FILLs after reset: w_index = 0,1,2,3. After 16 FILLs the next FILL uses w_index=0 (wrap).
- RD of an entry with e=0: resp_found=0 and resp_entry.vppn=0. RD of entry 5 returns vppn 0x1234 and ps=12.
- INV op=4, asid=0x3: invtlb_valid high one cycle with op=4, asid=0x3. INV op=9: no strobe, resp_inv_bad=1.
- Hold resp_ready=0 for 5 cycles: resp_valid and data stay stable, req_ready=0. A new req_valid is not accepted until the cycle after the handshake.
- Assert reset in the EXEC cycle of a WR: resp_valid=0, FSM=IDLE, fill_ptr=0, no further strobes.

Source files
------------

// File: rtl/tlb_mgr_pkg.sv
// Shared TLB types and constants for the TLB maintenance initiator.
package tlb_mgr_pkg;

    localparam int unsigned TLBNUM   = 16;
    localparam int unsigned TLBIDLEN = $clog2(TLBNUM);

    typedef enum logic [2:0] {
        TLB_SRCH = 3'd0,
        TLB_RD   = 3'd1,
        TLB_WR   = 3'd2,
        TLB_FILL = 3'd3,
        TLB_INV  = 3'd4
    } tlb_op_t;

    localparam logic [4:0] INV_ALL0          = 5'd0;
    localparam logic [4:0] INV_ALL1          = 5'd1;
    localparam logic [4:0] INV_GLOBAL        = 5'd2;
    localparam logic [4:0] INV_NONGLOBAL     = 5'd3;
    localparam logic [4:0] INV_ASID          = 5'd4;
    localparam logic [4:0] INV_ASID_VA       = 5'd5;
    localparam logic [4:0] INV_GLOBAL_ASID_VA = 5'd6;
    localparam logic [4:0] INV_OP_MAX        = INV_GLOBAL_ASID_VA;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic                found;
        logic [TLBIDLEN-1:0] index;
    } tlb_result_t;

    // An invalid entry read back keeps only its page size; the CSR file clears the rest.
    function automatic tlb_entry_t rd_clear(input tlb_entry_t ent);
        tlb_entry_t r;
        r    = '0;
        r.ps = ent.ps;
        return r;
    endfunction

    function automatic logic inv_op_bad(input logic [4:0] op);
        return op > INV_OP_MAX;
    endfunction

endpackage

// File: rtl/tlb_mgr_if.sv
// Bundle of pipeline request/response, CSR operands and TLB port signals for tlb_mgr.
interface tlb_mgr_if;
    import tlb_mgr_pkg::*;

    logic                req_valid;
    logic                req_ready;
    tlb_op_t             req_op;
    logic [4:0]          req_invop;
    logic [9:0]          req_inv_asid;
    logic [31:0]         req_inv_va;
    tlb_entry_t          csr_entry;
    logic [TLBIDLEN-1:0] csr_index;

    logic [18:0]         s_vppn;
    logic                s_va_bit12;
    logic [9:0]          s_asid;
    tlb_result_t         s_result;
    logic [TLBIDLEN-1:0] r_index;
    tlb_entry_t          r_entry;
    logic                we;
    logic [TLBIDLEN-1:0] w_index;
    tlb_entry_t          w_entry;
    logic                invtlb_valid;
    logic [4:0]          invtlb_op;
    logic [9:0]          invtlb_asid;
    logic [31:0]         invtlb_va;

    logic                resp_valid;
    logic                resp_ready;
    tlb_op_t             resp_op;
    logic                resp_found;
    logic [TLBIDLEN-1:0] resp_index;
    tlb_entry_t          resp_entry;
    logic                resp_inv_bad;

    modport slave (
        input  req_valid, req_op, req_invop, req_inv_asid, req_inv_va,
               csr_entry, csr_index, s_result, r_entry, resp_ready,
        output req_ready, s_vppn, s_va_bit12, s_asid, r_index,
               we, w_index, w_entry, invtlb_valid, invtlb_op, invtlb_asid, invtlb_va,
               resp_valid, resp_op, resp_found, resp_index, resp_entry, resp_inv_bad
    );

    modport master (
        output req_valid, req_op, req_invop, req_inv_asid, req_inv_va,
               csr_entry, csr_index, s_result, r_entry, resp_ready,
        input  req_ready, s_vppn, s_va_bit12, s_asid, r_index,
               we, w_index, w_entry, invtlb_valid, invtlb_op, invtlb_asid, invtlb_va,
               resp_valid, resp_op, resp_found, resp_index, resp_entry, resp_inv_bad
    );

endinterface

// File: rtl/tlb_fill_ptr.sv
// TLBFILL victim selection: wrapping index counter advanced once per fill.
module tlb_fill_ptr
    import tlb_mgr_pkg::*;
#(
    parameter int unsigned NUM = TLBNUM,
    parameter int unsigned W   = TLBIDLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = (ptr_q == W'(NUM - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/tlb_mgr.sv
// Serialises TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB ports, one op per IDLE->EXEC->RESP pass.
module tlb_mgr
    import tlb_mgr_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    tlb_mgr_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                req_ready_q;
    tlb_op_t             op_q;
    logic [4:0]          invop_q;
    logic [9:0]          inv_asid_q;
    logic [31:0]         inv_va_q;
    logic                we_q;
    logic                invtlb_valid_q;
    logic                resp_valid_q;
    tlb_op_t             resp_op_q;
    logic                resp_found_q;
    logic [TLBIDLEN-1:0] resp_index_q;
    tlb_entry_t          resp_entry_q;
    logic                resp_inv_bad_q;
    logic [TLBIDLEN-1:0] fill_ptr;
    logic                fill_inc;

    assign fill_inc = we_q && (op_q == TLB_FILL);

    tlb_fill_ptr #(
        .NUM (TLBNUM),
        .W   (TLBIDLEN)
    ) u_fill_ptr (
        .clk   (clk),
        .reset (reset),
        .inc_i (fill_inc),
        .ptr_o (fill_ptr)
    );

    // Strobes are registered at accept so they land in the single EXEC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            op_q           <= TLB_SRCH;
            invop_q        <= '0;
            inv_asid_q     <= '0;
            inv_va_q       <= '0;
            we_q           <= 1'b0;
            invtlb_valid_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_op_q      <= TLB_SRCH;
            resp_found_q   <= 1'b0;
            resp_index_q   <= '0;
            resp_entry_q   <= '0;
            resp_inv_bad_q <= 1'b0;
        end else begin
            we_q           <= 1'b0;
            invtlb_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_q        <= EXEC;
                        req_ready_q    <= 1'b0;
                        op_q           <= bus.req_op;
                        invop_q        <= bus.req_invop;
                        inv_asid_q     <= bus.req_inv_asid;
                        inv_va_q       <= bus.req_inv_va;
                        we_q           <= (bus.req_op == TLB_WR) || (bus.req_op == TLB_FILL);
                        invtlb_valid_q <= (bus.req_op == TLB_INV) && !inv_op_bad(bus.req_invop);
                    end
                end
                EXEC: begin
                    state_q        <= RESP;
                    resp_valid_q   <= 1'b1;
                    resp_op_q      <= op_q;
                    resp_found_q   <= 1'b0;
                    resp_inv_bad_q <= 1'b0;
                    case (op_q)
                        TLB_SRCH: begin
                            resp_found_q <= bus.s_result.found;
                            if (bus.s_result.found) begin
                                resp_index_q <= bus.s_result.index;
                            end
                        end
                        TLB_RD: begin
                            resp_found_q <= bus.r_entry.e;
                            resp_entry_q <= bus.r_entry.e ? bus.r_entry : rd_clear(bus.r_entry);
                        end
                        TLB_FILL: resp_index_q   <= fill_ptr;
                        TLB_INV:  resp_inv_bad_q <= inv_op_bad(invop_q);
                        default: ;
                    endcase
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;

    assign bus.s_vppn       = bus.csr_entry.vppn;
    assign bus.s_va_bit12   = 1'b0;
    assign bus.s_asid       = bus.csr_entry.asid;
    assign bus.r_index      = bus.csr_index;

    assign bus.we           = we_q;
    assign bus.w_index      = (op_q == TLB_FILL) ? fill_ptr : bus.csr_index;
    assign bus.w_entry      = bus.csr_entry;

    assign bus.invtlb_valid = invtlb_valid_q;
    assign bus.invtlb_op    = invop_q;
    assign bus.invtlb_asid  = inv_asid_q;
    assign bus.invtlb_va    = inv_va_q;

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_op      = resp_op_q;
    assign bus.resp_found   = resp_found_q;
    assign bus.resp_index   = resp_index_q;
    assign bus.resp_entry   = resp_entry_q;
    assign bus.resp_inv_bad = resp_inv_bad_q;

endmodule

// File: tb/tb_tlb_mgr.sv
// Directed bench for tlb_mgr against a small behavioural TLB array.
module tb_tlb_mgr;
    import tlb_mgr_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tlb_mgr_if bus ();

    tlb_mgr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;
    int inv_cnt     = 0;
    int both_cnt    = 0;
    int we_before;
    int inv_before;

    tlb_entry_t mem [TLBNUM];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) mem[i] <= '0;
        end else if (bus.we) begin
            mem[bus.w_index] <= bus.w_entry;
        end
    end

    always_comb begin
        bus.s_result = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (mem[i].e && mem[i].vppn == bus.s_vppn && (mem[i].g || mem[i].asid == bus.s_asid)) begin
                bus.s_result.found = 1'b1;
                bus.s_result.index = TLBIDLEN'(i);
            end
        end
    end

    assign bus.r_entry = mem[bus.r_index];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.we) we_cnt++;
            if (bus.invtlb_valid) inv_cnt++;
            if (bus.we && bus.invtlb_valid) both_cnt++;
        end
    end

    function automatic tlb_entry_t mk(input logic [18:0] vppn, input logic [5:0] ps, input logic e);
        tlb_entry_t r;
        r      = '0;
        r.vppn = vppn;
        r.ps   = ps;
        r.e    = e;
        r.v0   = 1'b1;
        r.ppn0 = 20'h00abc;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input tlb_op_t op, input logic [3:0] idx, input tlb_entry_t ent,
                         input logic [4:0] invop, input logic [9:0] asid, input logic [31:0] va);
        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.csr_index    = idx;
        bus.csr_entry    = ent;
        bus.req_invop    = invop;
        bus.req_inv_asid = asid;
        bus.req_inv_va   = va;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_op       = TLB_SRCH;
        bus.req_invop    = '0;
        bus.req_inv_asid = '0;
        bus.req_inv_va   = '0;
        bus.csr_entry    = '0;
        bus.csr_index    = '0;
        bus.resp_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_we", 64'(bus.we), 64'd0);
        chk("rst_invtlb_valid", 64'(bus.invtlb_valid), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_found", 64'(bus.resp_found), 64'd0);
        chk("rst_resp_index", 64'(bus.resp_index), 64'd0);
        chk("rst_resp_op", 64'(bus.resp_op), 64'd0);
        chk("rst_resp_inv_bad", 64'(bus.resp_inv_bad), 64'd0);
        chk("rst_resp_entry_vppn", 64'(bus.resp_entry.vppn), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            issue(TLB_FILL, 4'd0, mk(19'(32'h100 + i), 6'd12, 1'b1), 5'd0, 10'd0, 32'd0);
            chk("fill_we", 64'(bus.we), 64'd1);
            chk("fill_w_index", 64'(bus.w_index), 64'(i));
            step();
            chk("fill_we_one_cycle", 64'(bus.we), 64'd0);
            chk("fill_resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("fill_resp_op", 64'(bus.resp_op), 64'd3);
            chk("fill_resp_index", 64'(bus.resp_index), 64'(i));
            step();
            chk("fill_resp_done", 64'(bus.resp_valid), 64'd0);
        end

        issue(TLB_WR, 4'd5, mk(19'h1234, 6'd12, 1'b1), 5'd0, 10'd0, 32'd0);
        chk("wr_we", 64'(bus.we), 64'd1);
        chk("wr_w_index", 64'(bus.w_index), 64'd5);
        chk("wr_w_vppn", 64'(bus.w_entry.vppn), 64'h1234);
        chk("wr_no_inv", 64'(bus.invtlb_valid), 64'd0);
        step();
        chk("wr_we_one_cycle", 64'(bus.we), 64'd0);
        chk("wr_resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("wr_resp_op", 64'(bus.resp_op), 64'd2);
        step();

        issue(TLB_SRCH, 4'd0, mk(19'h1234, 6'd0, 1'b1), 5'd0, 10'd0, 32'd0);
        chk("srch_s_vppn", 64'(bus.s_vppn), 64'h1234);
        chk("srch_s_va_bit12", 64'(bus.s_va_bit12), 64'd0);
        chk("srch_no_we", 64'(bus.we), 64'd0);
        step();
        chk("srch_hit_found", 64'(bus.resp_found), 64'd1);
        chk("srch_hit_index", 64'(bus.resp_index), 64'd5);
        chk("srch_resp_op", 64'(bus.resp_op), 64'd0);
        step();

        issue(TLB_SRCH, 4'd0, mk(19'h7777, 6'd0, 1'b1), 5'd0, 10'd0, 32'd0);
        step();
        chk("srch_miss_found", 64'(bus.resp_found), 64'd0);
        chk("srch_miss_index_kept", 64'(bus.resp_index), 64'd5);
        step();

        issue(TLB_WR, 4'd9, mk(19'h5555, 6'd21, 1'b0), 5'd0, 10'd0, 32'd0);
        step();
        step();

        issue(TLB_RD, 4'd5, mk(19'h0, 6'd0, 1'b0), 5'd0, 10'd0, 32'd0);
        chk("rd_r_index", 64'(bus.r_index), 64'd5);
        step();
        chk("rd_found", 64'(bus.resp_found), 64'd1);
        chk("rd_vppn", 64'(bus.resp_entry.vppn), 64'h1234);
        chk("rd_ps", 64'(bus.resp_entry.ps), 64'd12);
        chk("rd_resp_op", 64'(bus.resp_op), 64'd1);
        step();

        issue(TLB_RD, 4'd9, mk(19'h0, 6'd0, 1'b0), 5'd0, 10'd0, 32'd0);
        step();
        chk("rd_inv_found", 64'(bus.resp_found), 64'd0);
        chk("rd_inv_vppn", 64'(bus.resp_entry.vppn), 64'd0);
        chk("rd_inv_ps", 64'(bus.resp_entry.ps), 64'd21);
        chk("rd_inv_ppn0", 64'(bus.resp_entry.ppn0), 64'd0);
        step();

        issue(TLB_INV, 4'd0, mk(19'h0, 6'd0, 1'b0), 5'd4, 10'h3, 32'h1234_5000);
        chk("inv_valid", 64'(bus.invtlb_valid), 64'd1);
        chk("inv_op", 64'(bus.invtlb_op), 64'd4);
        chk("inv_asid", 64'(bus.invtlb_asid), 64'h3);
        chk("inv_va", 64'(bus.invtlb_va), 64'h1234_5000);
        chk("inv_no_we", 64'(bus.we), 64'd0);
        step();
        chk("inv_valid_one_cycle", 64'(bus.invtlb_valid), 64'd0);
        chk("inv_bad_clear", 64'(bus.resp_inv_bad), 64'd0);
        chk("inv_resp_op", 64'(bus.resp_op), 64'd4);
        step();

        inv_before = inv_cnt;
        issue(TLB_INV, 4'd0, mk(19'h0, 6'd0, 1'b0), 5'd9, 10'h3, 32'd0);
        chk("inv9_no_strobe", 64'(bus.invtlb_valid), 64'd0);
        step();
        chk("inv9_bad", 64'(bus.resp_inv_bad), 64'd1);
        step();
        chk("inv9_strobe_count", 64'(inv_cnt), 64'(inv_before));

        bus.resp_ready = 1'b0;
        issue(TLB_SRCH, 4'd0, mk(19'h1234, 6'd0, 1'b1), 5'd0, 10'd0, 32'd0);
        step();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = TLB_WR;
        bus.csr_index = 4'd7;
        bus.csr_entry = mk(19'h7777, 6'd12, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("stall_resp_found", 64'(bus.resp_found), 64'd1);
            chk("stall_resp_index", 64'(bus.resp_index), 64'd5);
            chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
            chk("stall_no_we", 64'(bus.we), 64'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        step();
        chk("hs_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("hs_req_ready", 64'(bus.req_ready), 64'd1);
        chk("hs_not_accepted", 64'(bus.we), 64'd0);
        step();
        bus.req_valid = 1'b0;
        chk("post_hs_we", 64'(bus.we), 64'd1);
        chk("post_hs_w_index", 64'(bus.w_index), 64'd7);
        step();
        chk("post_hs_resp_op", 64'(bus.resp_op), 64'd2);
        step();

        for (int i = 4; i < 16; i++) begin
            issue(TLB_FILL, 4'd0, mk(19'(32'h200 + i), 6'd12, 1'b1), 5'd0, 10'd0, 32'd0);
            chk("fill_seq_w_index", 64'(bus.w_index), 64'(i));
            step();
            step();
        end
        issue(TLB_FILL, 4'd0, mk(19'h300, 6'd12, 1'b1), 5'd0, 10'd0, 32'd0);
        chk("fill_wrap_w_index", 64'(bus.w_index), 64'd0);
        step();
        chk("fill_wrap_resp_index", 64'(bus.resp_index), 64'd0);
        step();

        we_before = we_cnt;
        issue(TLB_WR, 4'd3, mk(19'h4444, 6'd12, 1'b1), 5'd0, 10'd0, 32'd0);
        chk("rstmid_we_before", 64'(bus.we), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_we", 64'(bus.we), 64'd0);
        chk("rstmid_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rstmid_req_ready", 64'(bus.req_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rstmid_hold_we", 64'(bus.we), 64'd0);
            chk("rstmid_hold_resp_valid", 64'(bus.resp_valid), 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_no_strobe", 64'(we_cnt), 64'(we_before));
        issue(TLB_FILL, 4'd0, mk(19'h500, 6'd12, 1'b1), 5'd0, 10'd0, 32'd0);
        chk("rstmid_fill_ptr", 64'(bus.w_index), 64'd0);
        step();
        step();

        chk("we_inv_exclusive", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
